// File: rtl/timebase_pkg.sv
// Lock-state encoding and tolerance helper shared by the seconds timebase and display levels.
package timebase_pkg;

    typedef enum logic [1:0] {
        StUnlocked = 2'b00,
        StAcquire  = 2'b01,
        StLocked   = 2'b10,
        StHoldover = 2'b11
    } lock_state_e;

    function automatic logic within_tol(input int unsigned a, input int unsigned b,
                                        input int unsigned tol);
        int unsigned diff;
        diff = (a > b) ? a - b : b - a;
        return diff <= tol;
    endfunction

endpackage

// File: rtl/pps_sync.sv
// Two-flop synchroniser plus delay flop; rise is high for one cycle per low-to-high input edge.
module pps_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pps_timebase.sv
// Seconds timebase: divides the AC tick by a selectable rate, aligns to GPS PPS and tracks lock.
module pps_timebase
    import timebase_pkg::*;
#(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned RATE0         = 60,
    parameter int unsigned RATE1         = 50,
    parameter int unsigned TOL           = 2,
    parameter int unsigned LOCK_COUNT    = 2,
    parameter int unsigned PPS_TIMEOUT_S = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             rate_sel,
    input  logic             pps_in,
    input  logic             pps_en,
    output logic             sec_pulse,
    output logic             colon,
    output logic [CNT_W-1:0] phase,
    output logic [1:0]       lock_state,
    output logic             pps_err,
    output logic [CNT_W-1:0] meas_ticks
);

    localparam int unsigned MissW = (PPS_TIMEOUT_S < 1) ? 1 : $clog2(PPS_TIMEOUT_S + 1);
    localparam int unsigned GoodW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [MissW-1:0] MissMax   = '1;
    localparam logic [MissW-1:0] MissLimit = MissW'(PPS_TIMEOUT_S);
    localparam logic [GoodW-1:0] GoodLimit = GoodW'(LOCK_COUNT);

    logic             pps_rise;
    logic             pps_evt;
    logic             free_wrap;
    logic             ivl_good;
    logic [CNT_W-1:0] rate_n;
    logic [CNT_W-1:0] half_n;
    logic [CNT_W-1:0] ivl_inc;
    logic [GoodW-1:0] good_inc;

    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] ivl_q, ivl_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic [MissW-1:0] miss_q, miss_d;
    logic [GoodW-1:0] good_q, good_d;
    logic             sec_q, sec_d;
    logic             err_q, err_d;
    lock_state_e      state_q, state_d;

    pps_sync u_pps_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pps_in),
        .rise     (pps_rise)
    );

    // Rises seen while disabled are dropped, not deferred.
    assign pps_evt  = pps_rise & ena & pps_en;
    assign rate_n   = rate_sel ? CNT_W'(RATE1) : CNT_W'(RATE0);
    assign half_n   = rate_n >> 1;
    assign ivl_inc  = (ivl_q == CntMax) ? ivl_q : ivl_q + 1'b1;
    assign ivl_good = within_tol(32'(ivl_inc), 32'(rate_n), TOL);
    assign good_inc = good_q + 1'b1;

    always_comb begin
        phase_d   = phase_q;
        ivl_d     = ivl_q;
        meas_d    = meas_q;
        miss_d    = miss_q;
        good_d    = good_q;
        state_d   = state_q;
        sec_d     = 1'b0;
        err_d     = 1'b0;
        free_wrap = 1'b0;

        if (ena) begin
            // An early PPS (second half) emits the pulse now; a late one was already counted.
            if (pps_evt) begin
                phase_d = '0;
                sec_d   = (phase_q >= half_n);
            end else if (phase_q >= rate_n - 1'b1) begin
                phase_d   = '0;
                sec_d     = 1'b1;
                free_wrap = 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end

            if (!pps_en) begin
                ivl_d   = '0;
                miss_d  = '0;
                good_d  = '0;
                state_d = StUnlocked;
            end else if (pps_evt) begin
                meas_d = ivl_inc;
                ivl_d  = '0;
                miss_d = '0;
                unique case (state_q)
                    StUnlocked: begin
                        state_d = StAcquire;
                        good_d  = '0;
                    end
                    StAcquire: begin
                        if (ivl_good) begin
                            good_d = good_inc;
                            if (good_inc >= GoodLimit) state_d = StLocked;
                        end else begin
                            err_d  = 1'b1;
                            good_d = '0;
                        end
                    end
                    StLocked: begin
                        if (!ivl_good) begin
                            err_d   = 1'b1;
                            good_d  = '0;
                            state_d = StAcquire;
                        end
                    end
                    StHoldover: begin
                        if (ivl_good) begin
                            state_d = StLocked;
                        end else begin
                            err_d   = 1'b1;
                            good_d  = '0;
                            state_d = StAcquire;
                        end
                    end
                endcase
            end else begin
                ivl_d = ivl_inc;
                if (free_wrap && (miss_q != MissMax)) miss_d = miss_q + 1'b1;
                if (miss_q == MissLimit) begin
                    if (state_q == StAcquire) state_d = StUnlocked;
                    else if (state_q == StLocked) state_d = StHoldover;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            ivl_q   <= '0;
            meas_q  <= '0;
            miss_q  <= '0;
            good_q  <= '0;
            sec_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= StUnlocked;
        end else begin
            phase_q <= phase_d;
            ivl_q   <= ivl_d;
            meas_q  <= meas_d;
            miss_q  <= miss_d;
            good_q  <= good_d;
            sec_q   <= sec_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign phase      = phase_q;
    assign sec_pulse  = sec_q;
    assign pps_err    = err_q;
    assign meas_ticks = meas_q;
    assign lock_state = state_q;
    assign colon      = (phase_q < half_n);

endmodule
